// File: rtl/exc_seq.sv
// Exception/ERET sequencer in front of the CP0 write port: it captures a MEM-stage event, stalls
// the pipeline, issues the CP0 writes one per cycle and finishes with a one-cycle flush.
module exc_seq #(
  parameter logic [31:0] EXC_VECTOR = 32'hBFC00380
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        mem_valid,
  input  logic [31:0] mem_pc,
  input  logic        mem_bd,
  input  logic        mem_exc,
  input  logic [4:0]  mem_exccode,
  input  logic [31:0] mem_badvaddr,
  input  logic        mem_eret,
  input  logic        mtc0_wen,
  input  logic [7:0]  mtc0_addr,
  input  logic [31:0] mtc0_wdata,
  input  logic [31:0] cp0_status,
  input  logic [31:0] cp0_cause,
  input  logic [31:0] cp0_epc,
  output logic        cp0_wen,
  output logic [7:0]  cp0_addr,
  output logic [31:0] cp0_wdata,
  output logic        busy,
  output logic        flush,
  output logic [31:0] redirect_pc
);

  localparam logic [7:0] AddrBadv   = 8'h40;
  localparam logic [7:0] AddrStatus = 8'h60;
  localparam logic [7:0] AddrCause  = 8'h68;
  localparam logic [7:0] AddrEpc    = 8'h70;

  typedef enum logic [2:0] {
    StIdle,
    StWEpc,
    StWBadv,
    StWCause,
    StWStatus,
    StWEret
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, badvaddr_q, status_q, cause_q, epc_q;
  logic        bd_q, exl_q;
  logic [4:0]  exccode_q;

  logic        int_pend, ev_int, ev_exc, ev_eret, accept;
  logic [4:0]  acc_exccode;
  logic        acc_needs_badv, needs_badv;

  assign int_pend = (|(cp0_cause[15:8] & cp0_status[15:8])) & cp0_status[0] & ~cp0_status[1];
  assign ev_int   = mem_valid & int_pend;
  assign ev_exc   = mem_valid & ~int_pend & mem_exc;
  assign ev_eret  = mem_valid & ~int_pend & ~mem_exc & mem_eret;
  assign accept   = (state_q == StIdle) & (ev_int | ev_exc | ev_eret);

  // An interrupt overrides whatever exception the instruction carried.
  assign acc_exccode    = ev_int ? 5'd0 : mem_exccode;
  assign acc_needs_badv = (acc_exccode == 5'd4) | (acc_exccode == 5'd5);
  assign needs_badv     = (exccode_q == 5'd4) | (exccode_q == 5'd5);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= StIdle;
      pc_q       <= '0;
      bd_q       <= 1'b0;
      exccode_q  <= '0;
      badvaddr_q <= '0;
      exl_q      <= 1'b0;
      status_q   <= '0;
      cause_q    <= '0;
      epc_q      <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        pc_q       <= mem_pc;
        bd_q       <= mem_bd;
        exccode_q  <= acc_exccode;
        badvaddr_q <= mem_badvaddr;
        exl_q      <= cp0_status[1];
        status_q   <= cp0_status;
        cause_q    <= cp0_cause;
        epc_q      <= cp0_epc;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    cp0_wen     = 1'b0;
    cp0_addr    = '0;
    cp0_wdata   = '0;
    busy        = 1'b1;
    flush       = 1'b0;
    redirect_pc = '0;
    case (state_q)
      StIdle: begin
        busy = accept;
        if (accept) begin
          // The MTC0 of the accept cycle is dropped; the pipeline replays it if needed.
          if (ev_eret) begin
            state_d = StWEret;
          end else if (!cp0_status[1]) begin
            state_d = StWEpc;
          end else if (acc_needs_badv) begin
            state_d = StWBadv;
          end else begin
            state_d = StWCause;
          end
        end else begin
          cp0_wen   = mtc0_wen;
          cp0_addr  = mtc0_addr;
          cp0_wdata = mtc0_wdata;
        end
      end
      StWEpc: begin
        cp0_wen   = 1'b1;
        cp0_addr  = AddrEpc;
        cp0_wdata = bd_q ? (pc_q - 32'd4) : pc_q;
        state_d   = needs_badv ? StWBadv : StWCause;
      end
      StWBadv: begin
        cp0_wen   = 1'b1;
        cp0_addr  = AddrBadv;
        cp0_wdata = badvaddr_q;
        state_d   = StWCause;
      end
      StWCause: begin
        cp0_wen   = 1'b1;
        cp0_addr  = AddrCause;
        // A nested exception keeps the BD bit of the original one.
        cp0_wdata = {exl_q ? cause_q[31] : bd_q, cause_q[30:7], exccode_q, cause_q[1:0]};
        state_d   = StWStatus;
      end
      StWStatus: begin
        cp0_wen     = 1'b1;
        cp0_addr    = AddrStatus;
        cp0_wdata   = status_q | 32'h2;
        flush       = 1'b1;
        redirect_pc = EXC_VECTOR;
        state_d     = StIdle;
      end
      StWEret: begin
        cp0_wen     = 1'b1;
        cp0_addr    = AddrStatus;
        cp0_wdata   = status_q & ~32'h2;
        flush       = 1'b1;
        redirect_pc = epc_q;
        state_d     = StIdle;
      end
      default: begin
        busy    = 1'b0;
        state_d = StIdle;
      end
    endcase
  end

endmodule

// File: tb/tb_exc_seq.sv
// Scoreboard bench for exc_seq: stimulus pushes expected CP0 writes tagged with their cycle,
// a negedge monitor pops and compares each one the DUT presents.
module tb_exc_seq;

  logic        clk, resetn;
  logic        mem_valid, mem_bd, mem_exc, mem_eret, mtc0_wen;
  logic [31:0] mem_pc, mem_badvaddr, mtc0_wdata, cp0_status, cp0_cause, cp0_epc;
  logic [4:0]  mem_exccode;
  logic [7:0]  mtc0_addr;
  logic        cp0_wen, busy, flush;
  logic [7:0]  cp0_addr;
  logic [31:0] cp0_wdata, redirect_pc;

  exc_seq #(.EXC_VECTOR(32'hBFC00380)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .mem_valid   (mem_valid),
    .mem_pc      (mem_pc),
    .mem_bd      (mem_bd),
    .mem_exc     (mem_exc),
    .mem_exccode (mem_exccode),
    .mem_badvaddr(mem_badvaddr),
    .mem_eret    (mem_eret),
    .mtc0_wen    (mtc0_wen),
    .mtc0_addr   (mtc0_addr),
    .mtc0_wdata  (mtc0_wdata),
    .cp0_status  (cp0_status),
    .cp0_cause   (cp0_cause),
    .cp0_epc     (cp0_epc),
    .cp0_wen     (cp0_wen),
    .cp0_addr    (cp0_addr),
    .cp0_wdata   (cp0_wdata),
    .busy        (busy),
    .flush       (flush),
    .redirect_pc (redirect_pc)
  );

  typedef struct {
    int          cyc;
    logic [7:0]  addr;
    logic [31:0] data;
    logic        flush;
    logic [31:0] rpc;
    logic        busy;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   t0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, got, want);
    end
  endtask

  task automatic push(input int c, input logic [7:0] a, input logic [31:0] d, input logic f,
                      input logic [31:0] r, input logic b);
    exp_t e;
    e.cyc = c; e.addr = a; e.data = d; e.flush = f; e.rpc = r; e.busy = b;
    q.push_back(e);
  endtask

  // Monitor: every presented write or flush must match the next expected entry.
  always @(negedge clk) begin
    if (resetn && (cp0_wen || flush)) begin
      n_tests++;
      if (q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected: cyc=%0d addr=%h data=%h flush=%b", cyc, cp0_addr,
                 cp0_wdata, flush);
      end else begin
        exp_t e;
        e = q.pop_front();
        if (e.cyc != cyc || !cp0_wen || cp0_addr !== e.addr || cp0_wdata !== e.data ||
            flush !== e.flush || redirect_pc !== e.rpc || busy !== e.busy) begin
          n_fail++;
          $display("FAIL sb_write: got cyc=%0d wen=%b addr=%h data=%h flush=%b rpc=%h busy=%b want cyc=%0d addr=%h data=%h flush=%b rpc=%h busy=%b",
                   cyc, cp0_wen, cp0_addr, cp0_wdata, flush, redirect_pc, busy,
                   e.cyc, e.addr, e.data, e.flush, e.rpc, e.busy);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    mem_valid = 1'b0; mem_exc = 1'b0; mem_eret = 1'b0; mtc0_wen = 1'b0;
  endtask

  task automatic snoop(input logic [31:0] st, input logic [31:0] ca, input logic [31:0] ep);
    cp0_status = st; cp0_cause = ca; cp0_epc = ep;
  endtask

  task automatic exc(input logic [31:0] pc, input logic bd, input logic [4:0] code,
                     input logic [31:0] badv);
    mem_valid = 1'b1; mem_pc = pc; mem_bd = bd; mem_exc = 1'b1; mem_exccode = code;
    mem_badvaddr = badv;
  endtask

  initial begin
    resetn = 1'b0;
    idle_inputs();
    mem_pc = '0; mem_bd = 1'b0; mem_exccode = '0; mem_badvaddr = '0;
    mtc0_addr = '0; mtc0_wdata = '0;
    snoop(32'h0, 32'h0, 32'h0);

    #3;
    chk("rst_wen", {31'd0, cp0_wen}, 32'd0);
    chk("rst_addr", {24'd0, cp0_addr}, 32'd0);
    chk("rst_wdata", cp0_wdata, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_flush", {31'd0, flush}, 32'd0);
    chk("rst_rpc", redirect_pc, 32'd0);
    tick(); tick();
    resetn = 1'b1;
    tick();

    // MTC0 pass-through
    mtc0_wen = 1'b1; mtc0_addr = 8'h60; mtc0_wdata = 32'h0000FF01;
    push(cyc, 8'h60, 32'h0000FF01, 1'b0, 32'h0, 1'b0);
    #1 chk("mtc0_busy", {31'd0, busy}, 32'd0);
    tick(); idle_inputs();

    // Event without mem_valid is ignored
    mem_exc = 1'b1; mem_exccode = 5'd8;
    #1 chk("novalid_busy", {31'd0, busy}, 32'd0);
    tick(); chk("novalid_busy_next", {31'd0, busy}, 32'd0);
    idle_inputs();

    // Syscall in delay slot; concurrent MTC0 dropped; snoops change mid-sequence
    tick(); t0 = cyc;
    snoop(32'h0, 32'h0, 32'h0);
    exc(32'hBFC00100, 1'b1, 5'd8, 32'h0);
    mtc0_wen = 1'b1; mtc0_addr = 8'h60; mtc0_wdata = 32'hDEADBEEF;
    push(t0 + 1, 8'h70, 32'hBFC000FC, 1'b0, 32'h0, 1'b1);
    push(t0 + 2, 8'h68, 32'h80000020, 1'b0, 32'h0, 1'b1);
    push(t0 + 3, 8'h60, 32'h00000002, 1'b1, 32'hBFC00380, 1'b1);
    #1 chk("sys_busy_accept", {31'd0, busy}, 32'd1);
    chk("sys_mtc0_dropped", {31'd0, cp0_wen}, 32'd0);
    tick(); idle_inputs(); mem_bd = 1'b0;
    snoop(32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF);
    repeat (3) tick();
    chk("sys_idle_after", {31'd0, busy}, 32'd0);
    snoop(32'h0, 32'h0, 32'h0);

    // AdEL with BadVAddr
    tick(); t0 = cyc;
    exc(32'h80000010, 1'b0, 5'd4, 32'h00000003);
    push(t0 + 1, 8'h70, 32'h80000010, 1'b0, 32'h0, 1'b1);
    push(t0 + 2, 8'h40, 32'h00000003, 1'b0, 32'h0, 1'b1);
    push(t0 + 3, 8'h68, 32'h00000010, 1'b0, 32'h0, 1'b1);
    push(t0 + 4, 8'h60, 32'h00000002, 1'b1, 32'hBFC00380, 1'b1);
    tick(); idle_inputs();
    repeat (5) tick();

    // Interrupt beats simultaneous exception and ERET
    snoop(32'h00000401, 32'h00000400, 32'h0);
    tick(); t0 = cyc;
    exc(32'h80001000, 1'b0, 5'd10, 32'h0);
    mem_eret = 1'b1;
    push(t0 + 1, 8'h70, 32'h80001000, 1'b0, 32'h0, 1'b1);
    push(t0 + 2, 8'h68, 32'h00000400, 1'b0, 32'h0, 1'b1);
    push(t0 + 3, 8'h60, 32'h00000403, 1'b1, 32'hBFC00380, 1'b1);
    tick(); idle_inputs(); snoop(32'h0, 32'h0, 32'h0);
    repeat (4) tick();

    // Nested (EXL=1): no EPC write, Cause BD preserved
    snoop(32'h00000002, 32'h80000000, 32'h0);
    tick(); t0 = cyc;
    exc(32'h80002000, 1'b0, 5'd8, 32'h0);
    push(t0 + 1, 8'h68, 32'h80000020, 1'b0, 32'h0, 1'b1);
    push(t0 + 2, 8'h60, 32'h00000002, 1'b1, 32'hBFC00380, 1'b1);
    tick(); idle_inputs();
    repeat (3) tick();

    // Nested AdES: BadVAddr written, instruction BD ignored
    snoop(32'h00000002, 32'h0, 32'h0);
    tick(); t0 = cyc;
    exc(32'h80003000, 1'b1, 5'd5, 32'h00001234);
    push(t0 + 1, 8'h40, 32'h00001234, 1'b0, 32'h0, 1'b1);
    push(t0 + 2, 8'h68, 32'h00000014, 1'b0, 32'h0, 1'b1);
    push(t0 + 3, 8'h60, 32'h00000002, 1'b1, 32'hBFC00380, 1'b1);
    tick(); idle_inputs(); mem_bd = 1'b0;
    repeat (4) tick();

    // ERET, then a second ERET accepted right after the flush
    snoop(32'h0000FF03, 32'h0, 32'hBFC00200);
    tick(); t0 = cyc;
    mem_valid = 1'b1; mem_eret = 1'b1;
    push(t0 + 1, 8'h60, 32'h0000FF01, 1'b1, 32'hBFC00200, 1'b1);
    tick(); idle_inputs();
    tick();
    snoop(32'h0, 32'h0, 32'h80000000);
    mem_valid = 1'b1; mem_eret = 1'b1;
    push(t0 + 3, 8'h60, 32'h00000000, 1'b1, 32'h80000000, 1'b1);
    #1 chk("eret2_accept_busy", {31'd0, busy}, 32'd1);
    tick(); idle_inputs();
    repeat (2) tick();
    snoop(32'h0, 32'h0, 32'h0);

    // Reset during W_CAUSE
    tick(); t0 = cyc;
    exc(32'h80000020, 1'b0, 5'd12, 32'h0);
    push(t0 + 1, 8'h70, 32'h80000020, 1'b0, 32'h0, 1'b1);
    tick(); idle_inputs();
    tick();
    resetn = 1'b0;
    #1;
    chk("rstmid_wen", {31'd0, cp0_wen}, 32'd0);
    chk("rstmid_busy", {31'd0, busy}, 32'd0);
    chk("rstmid_flush", {31'd0, flush}, 32'd0);
    tick();
    resetn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rstrel_busy", {31'd0, busy}, 32'd0);
      chk("rstrel_flush", {31'd0, flush}, 32'd0);
    end

    tick();
    chk("sb_drain", q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/exc_seq.md
# exc_seq

Exception/ERET sequencer sitting directly upstream of the CP0 register file. Owns CP0's single write port (`wen`/`addr`/`wdata`), arbitrating between MTC0 pass-through and multi-cycle exception entry and ERET sequences. On an exception, interrupt or ERET from the MEM stage it:
- captures the event,
- stalls the pipeline,
- issues the required CP0 writes one per cycle,
- ends with a one-cycle flush and redirect to the front end.

## Interface
- `EXC_VECTOR`, default 32'hBFC00380: exception entry PC.
- `clk`  in  1  — single clock, rising edge.
- `resetn`  in  1  — reset, asynchronous, active-low.
- `mem_valid`  in  1  — MEM-stage instruction valid.
- `mem_pc`  in  32  — PC of MEM-stage instruction.
- `mem_bd`  in  1  — instruction is in a branch delay slot.
- `mem_exc`  in  1  — synchronous exception raised by instruction.
- `mem_exccode`  in  5  — ExcCode for `mem_exc`.
- `mem_badvaddr`  in  32  — faulting address (used for ExcCode 4/5 only).
- `mem_eret`  in  1  — instruction is ERET.
- `mtc0_wen`  in  1  — MTC0 write request.
- `mtc0_addr`  in  8  — CP0 address, `{rd[4:0], sel[2:0]}`.
- `mtc0_wdata`  in  32  — MTC0 data.
- `cp0_status`  in  32  — current Status snoop.
- `cp0_cause`  in  32  — current Cause snoop.
- `cp0_epc`  in  32  — current EPC snoop.
- `cp0_wen`  out  1  — CP0 write enable.
- `cp0_addr`  out  8  — CP0 write address.
- `cp0_wdata`  out  32  — CP0 write data.
- `busy`  out  1  — stall request to pipeline.
- `flush`  out  1  — one-cycle pipeline flush.
- `redirect_pc`  out  32  — fetch target, valid when `flush`=1.

## Operation
CP0 addresses:
- BadVAddr = 8'h40
- Status = 8'h60
- Cause = 8'h68
- EPC = 8'h70

Event detection, IDLE only, requires `mem_valid`=1. Priority order:
1. **Interrupt:** `int_pend = |(cp0_cause[15:8] & cp0_status[15:8]) & cp0_status[0] & ~cp0_status[1]`. Taken with ExcCode 0.
2. **Synchronous exception:** `mem_exc`.
3. **ERET:** `mem_eret`.

Accept cycle:
- Capture into registers: pc, bd, exccode, badvaddr, exl (`cp0_status[1]`), status, cause, epc.
- Any MTC0 presented in the accept cycle is dropped.

FSM states: IDLE, W_EPC, W_BADV, W_CAUSE, W_STATUS, W_ERET.
- **IDLE → W_EPC:** interrupt/exception with captured exl=0.
- **IDLE → W_BADV or W_CAUSE:** interrupt/exception with exl=1. Go to W_BADV if exccode ∈ {4,5}, else W_CAUSE. EPC is not written.
- **IDLE → W_ERET:** ERET.
- **W_EPC:** write EPC = bd ? pc−4 : pc. Next state is W_BADV if exccode ∈ {4,5}, else W_CAUSE.
- **W_BADV:** write BadVAddr = captured badvaddr. Next state W_CAUSE.
- **W_CAUSE:** write Cause = `{exl ? cause[31] : bd, cause[30:7], exccode, cause[1:0]}`. Next state W_STATUS.
- **W_STATUS:** write Status = status | 32'h2. Assert `flush`, `redirect_pc`=EXC_VECTOR. Next state IDLE.
- **W_ERET:** write Status = status & ~32'h2. Assert `flush`, `redirect_pc`=captured epc. Next state IDLE.

Outputs by state:
- In IDLE with no event: `cp0_wen/addr/wdata` = `mtc0_*` combinationally.
- `busy` = (state≠IDLE) | event accepted this cycle.
- While busy, MTC0 is ignored; the stalled pipeline holds it.

## Timing
- Reset (async, any state): state=IDLE and all captured registers 0. Non-pass-through outputs: `cp0_wen`=0, `cp0_addr`=0, `cp0_wdata`=0, `busy`=0, `flush`=0, `redirect_pc`=0. No partial flush after reset release.
- Accept at cycle T. Exception, exl=0, no BadVAddr:
  - T+1 EPC write
  - T+2 Cause write
  - T+3 Status write + flush
  - `busy` high T..T+3
- ExcCode 4/5 adds BadVAddr at T+2, shifting the rest by one: flush at T+4.
- exl=1 removes the EPC cycle.
- ERET: Status write + flush at T+1.
- Outputs in non-IDLE states are Moore, derived from state and captured registers only; mid-sequence changes of snoop inputs have no effect.
- Simultaneous interrupt + `mem_exc` + `mem_eret`: interrupt taken, ExcCode 0, instruction flushed.
- `flush` is exactly one cycle per event; IDLE can accept a new event on the cycle after flush.

## Test plan
- **MTC0 pass-through:** IDLE, `mtc0_wen`=1, addr 8'h60, data 32'h0000FF01 → same cycle `cp0_wen`=1, addr 8'h60, data 32'h0000FF01, `busy`=0.
- **Syscall:**
  - Stimulus: exccode 8, pc 32'hBFC00100, bd=1, status 32'h0, cause 32'h0.
  - Response: T+1 EPC←32'hBFC000FC; T+2 Cause←32'h80000020; T+3 Status←32'h2 with flush, `redirect_pc`=32'hBFC00380.
- **AdEL:**
  - Stimulus: exccode 4, badvaddr 32'h00000003, pc 32'h80000010, bd=0.
  - Response: EPC, BadVAddr=32'h3, Cause code 4, Status writes on T+1..T+4; flush at T+4.
- **Interrupt vs. simultaneous exception:**
  - Stimulus: status 32'h00000401, cause 32'h00000400, `mem_exc`=1 code 10.
  - Response: Cause ExcCode=0; the RI exception is not recorded.
- **Nested EXL and ERET:**
  - Exception with status 32'h2 → no EPC write; Cause BD preserved; flush at T+2.
  - ERET with epc 32'hBFC00200 → T+1 Status←status&~2, flush, `redirect_pc`=32'hBFC00200.
- **Reset mid-sequence:** assert `resetn`=0 during W_CAUSE → immediately `cp0_wen`=0, `busy`=0, `flush`=0. After release: IDLE, no flush.
